// File: rtl/lab_pkg.sv
// Board-level constants shared by the lab datapath blocks.
package lab_pkg;

    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;

    // Clock cycles spanned by a period given in milliseconds.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One-bit 2-flop synchroniser followed by a stable-level counter.
module debounce_bit #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic flip
);

    localparam int unsigned CNT_W = $clog2(CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // High on the edge where the new level is accepted.
    assign flip = (sync2 != dout) && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Debounces the board switch/button bus; pulses changed whenever out updates.
module sw_debounce
    import lab_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             changed
);

    logic [WIDTH-1:0] flips;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .din (in[i]),
            .dout(out[i]),
            .flip(flips[i])
        );
    end

    // Registered alongside out so the strobe rises on the update edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed <= 1'b0;
        end else begin
            changed <= |flips;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed vector table plus randomized run against a sample-history model.
module tb_sw_debounce;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         changed;

    int checks = 0;
    int errors = 0;

    sw_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in     (din),
        .out    (dout),
        .changed(changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [W-1:0] din;
        logic [W-1:0] exp_out;
        logic         exp_ch;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [W-1:0] d,
                       input logic [W-1:0] eo, input logic ec, input int reps);
        vec_t v;
        for (int k = 0; k < reps; k++) begin
            v.rst = r; v.din = d; v.exp_out = eo; v.exp_ch = ec;
            vecs.push_back(v);
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] eo, input logic ec);
        checks++;
        if (dout !== eo) begin
            errors++;
            $display("FAIL %s out: got %h expected %h at %0t", name, dout, eo, $time);
        end
        checks++;
        if (changed !== ec) begin
            errors++;
            $display("FAIL %s changed: got %b expected %b at %0t", name, changed, ec, $time);
        end
    endtask

    // Model: a bit takes a new level once the last N synchronised samples
    // all disagree with it; the synchroniser delays each sample by two edges.
    logic [W-1:0] m_out;
    logic         m_ch;
    logic [W-1:0] samp[$];
    logic [W-1:0] seen[$];

    task automatic model_reset();
        m_out = '0;
        m_ch  = 1'b0;
        samp.delete();
        samp.push_back('0);
        samp.push_back('0);
        seen.delete();
    endtask

    task automatic model_edge(input logic [W-1:0] v);
        logic [W-1:0] flips;
        logic         all_diff;
        samp.push_back(v);
        seen.push_back(samp[samp.size()-3]);
        if (samp.size() > 8) void'(samp.pop_front());
        if (seen.size() > 8) void'(seen.pop_front());
        flips = '0;
        if (seen.size() >= N) begin
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < N; k++)
                    if (seen[seen.size()-1-k][b] == m_out[b]) all_diff = 1'b0;
                flips[b] = all_diff;
            end
        end
        m_out = m_out ^ flips;
        m_ch  = |flips;
    endtask

    logic [W-1:0] lvl;
    int           hold[W];

    initial begin
        rst = 1'b1;
        din = '0;

        // Reset with input high, then accept 8'hFF at edge 6.
        add(1, 8'hFF, 8'h00, 0, 2);
        add(0, 8'hFF, 8'h00, 0, 5);
        add(0, 8'hFF, 8'hFF, 1, 1);
        add(0, 8'hFF, 8'hFF, 0, 2);
        // Release path.
        add(0, 8'h00, 8'hFF, 0, 5);
        add(0, 8'h00, 8'h00, 1, 1);
        add(0, 8'h00, 8'h00, 0, 2);
        // Short glitch on bit 0.
        add(0, 8'h01, 8'h00, 0, 3);
        add(0, 8'h00, 8'h00, 0, 6);
        // Bounce on bit 3: 1,0,1,1,0,1 then hold.
        add(0, 8'h08, 8'h00, 0, 1);
        add(0, 8'h00, 8'h00, 0, 1);
        add(0, 8'h08, 8'h00, 0, 2);
        add(0, 8'h00, 8'h00, 0, 1);
        add(0, 8'h08, 8'h00, 0, 5);
        add(0, 8'h08, 8'h08, 1, 1);
        add(0, 8'h08, 8'h08, 0, 2);
        // Back to zero, then simultaneous 8'hA5.
        add(0, 8'h00, 8'h08, 0, 5);
        add(0, 8'h00, 8'h00, 1, 1);
        add(0, 8'h00, 8'h00, 0, 1);
        add(0, 8'hA5, 8'h00, 0, 5);
        add(0, 8'hA5, 8'hA5, 1, 1);
        add(0, 8'hA5, 8'hA5, 0, 2);
        // Staggered: bit 7 clears, bit 1 sets a cycle later.
        add(0, 8'h25, 8'hA5, 0, 1);
        add(0, 8'h27, 8'hA5, 0, 4);
        add(0, 8'h27, 8'h25, 1, 1);
        add(0, 8'h27, 8'h27, 1, 1);
        add(0, 8'h27, 8'h27, 0, 2);
        // Reset mid-count with 8'h01 held.
        add(1, 8'h01, 8'h00, 0, 1);
        add(0, 8'h01, 8'h00, 0, 3);
        add(1, 8'h01, 8'h00, 0, 1);
        add(0, 8'h01, 8'h00, 0, 5);
        add(0, 8'h01, 8'h01, 1, 1);
        add(0, 8'h01, 8'h01, 0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            din = vecs[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_ch);
        end

        // Randomized run: per-bit hold lengths straddle the debounce window.
        rst = 1'b1;
        din = '0;
        lvl = '0;
        for (int b = 0; b < W; b++) hold[b] = 0;
        @(posedge clk);
        #1;
        model_reset();
        check("rand_reset", m_out, m_ch);
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                model_reset();
                check("rand_rst_pulse", m_out, m_ch);
                rst = 1'b0;
            end else begin
                for (int b = 0; b < W; b++) begin
                    if (hold[b] == 0) begin
                        lvl[b]  = 1'($urandom_range(0, 1));
                        hold[b] = $urandom_range(1, 8);
                    end
                    hold[b]--;
                end
                din = lvl;
                @(posedge clk);
                #1;
                model_edge(din);
                check("rand", m_out, m_ch);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Synchronises and debounces the 8 board slide-switch/push-button inputs before they drive the lab datapath, so the switch-to-LED stage downstream sees a clean, glitch-free 8-bit bus. Each bit is brought through a 2-flop synchroniser, then accepted only after it has held a new level for `DEBOUNCE_CYCLES` consecutive clocks. A one-cycle `changed` strobe marks every update of the output bus.

## Interface
- `WIDTH`, default 8: number of independent input bits.
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive stable cycles required to accept a new level. Legal range is 2 or more.
- `clk` input, 1 bit: the single clock of the block; all state updates on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high. It clears all state immediately.
- `in` input, `WIDTH` bits: raw, asynchronous switch/button levels.
- `out` output, `WIDTH` bits: debounced levels, registered.
- `changed` output, 1 bit: registered pulse, high for exactly one cycle when any bit of `out` updates.

## Operation
- **Per-bit pipeline:**
  - `sync1 <= in[i]`, then `sync2 <= sync1`.
  - Counter `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide.
  - Stable register `stable` drives `out[i]`.
- **Each clock, per bit:**
  - `sync2 == stable`: `cnt <= 0`.
  - `sync2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `sync2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`, and the bit's `flip` is asserted for that cycle.
- **Change strobe:** `changed <= |flip` is registered, so it rises on the same edge that `out` updates.
- **Bounce or glitch:** any return of `sync2` to `stable` before the count completes resets `cnt` to 0 and leaves no effect on `out`. A glitch shorter than `DEBOUNCE_CYCLES` synced cycles never propagates.
- **Bit independence:** bits are fully independent. Several bits may flip on the same edge, giving a single `changed` pulse. Flips on consecutive edges give `changed` high on both cycles.
- **Counter range:** the counter never exceeds `DEBOUNCE_CYCLES-1`, so no wrap-around is possible.
- **No FSM beyond the per-bit compare/count:** states are implicit. IDLE is `cnt == 0`; COUNTING is `cnt > 0`.

## Timing
- **Reset values:** `rst` high forces `sync1`, `sync2`, `cnt`, `out` and `changed` to 0 asynchronously.
- **After reset release:**
  - Nonzero `in` is treated as a change from 0.
  - Those bits appear on `out` after the full debounce latency.
- **Latency:** for an input level held steady and first sampled at edge 1:
  - `sync2` holds the new level after edge 2.
  - `cnt` increments on edges 3 through N+1 (N = `DEBOUNCE_CYCLES`).
  - `out` and `changed` update at edge N+2.
  - `changed` drops at edge N+3 unless another bit flips then.
- **Asynchronous inputs:** edges on `in` arriving within a cycle of a clock edge may add one cycle of latency (synchroniser resolution). Benches must allow N+2 or N+3.
- **Reset mid-count:** partial counts are discarded, `out` returns to 0, and no `changed` pulse is emitted on reset.

## Structure
- Shared package `lab_pkg` holds `CLK_HZ` (50_000_000) and `DEBOUNCE_MS` (10). The top-level computes the default `DEBOUNCE_CYCLES` from these.
- One natural sub-module, `debounce_bit`, instantiated `WIDTH` times via generate:
  - contains the synchroniser, counter and stable register for one bit;
  - ports are `clk`, `rst`, `din`, `dout`, `flip`.
- `sw_debounce` ORs the `flip` outputs and registers `changed`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- **Reset with input high:** hold `in`=8'hFF through reset, then release.
  - `out`=8'h00 immediately after release.
  - `out`=8'hFF at edge 6, with `changed`=1 for exactly one cycle.
- **Short glitch:** from stable `out`=8'h00, drive `in[0]`=1 for 3 cycles, then 0.
  - `out` stays 8'h00 and `changed` never asserts.
- **Bounce then settle:** from stable 8'h00, drive `in[3]` with the pattern 1,0,1,1,0,1, then hold 1.
  - `out`=8'h08 exactly 6 edges after the final rise is sampled.
  - Exactly one `changed` pulse.
- **Simultaneous and staggered bits:**
  - `in` goes 8'h00 to 8'hA5 in one cycle: `out`=8'hA5 with a single one-cycle `changed`.
  - Then `in[7]` clears and `in[1]` sets one cycle apart: two `out` updates on consecutive edges, so `changed` is high for 2 cycles.
- **Reset mid-count:** `in`=8'h01 held, with `rst` pulsed at edge 4.
  - `out` stays 0 with no `changed` pulse.
  - `out`=8'h01 at edge 6 after reset release.
- **Release path:** stable `out`=8'hFF, then `in` drops to 8'h00.
  - `out`=8'h00 at edge 6 with one `changed` pulse.
